// File: rtl/tlb_plru_set.sv
// Set-associative TLB with a tree-PLRU replacement policy per set.
// One-cycle registered lookup, single-cycle fill, and a per-set flush walker.
// Optional feature macro: TLB_PCID_FLUSH_EN -- when defined, a flush clears only
// entries whose pcid matches the latched flush_pcid and leaves the PLRU trees alone;
// when undefined, a flush clears every entry and zeroes the PLRU trees.
module tlb_plru_set #(
  parameter int unsigned SADDR = 64,
  parameter int unsigned SPAGE = 12,
  parameter int unsigned NSET  = 8,
  parameter int unsigned NWAY  = 8,
  parameter int unsigned SPCID = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lu_valid,
  input  logic [SADDR-1:0]       lu_va,
  input  logic [SPCID-1:0]       lu_pcid,
  output logic                   lu_done,
  output logic                   lu_hit,
  output logic [SADDR-SPAGE-1:0] lu_pa,
  input  logic                   fill_valid,
  output logic                   fill_ready,
  input  logic [SADDR-1:0]       fill_va,
  input  logic [SPCID-1:0]       fill_pcid,
  input  logic [SADDR-SPAGE-1:0] fill_pa,
  input  logic                   flush_req,
  input  logic [SPCID-1:0]       flush_pcid,
  output logic                   flush_busy
);

  localparam int unsigned SIDX = $clog2(NSET);
  localparam int unsigned SWAY = $clog2(NWAY);
  localparam int unsigned STAG = SADDR - SPAGE - SIDX;
  localparam int unsigned SPPN = SADDR - SPAGE;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  localparam logic [SIDX-1:0] LAST_SET = SIDX'(NSET - 1);

  // Entry storage; tag/pcid/pa are not reset, valid masks stale contents.
  logic [NWAY-1:0]  valid_q [NSET];
  logic [NWAY-2:0]  plru_q  [NSET];
  logic [STAG-1:0]  tag_q   [NSET][NWAY];
  logic [SPCID-1:0] pcid_q  [NSET][NWAY];
  logic [SPPN-1:0]  pa_q    [NSET][NWAY];

  logic [0:0]      state_q;
  logic [SIDX-1:0] cnt_q;

  // Point every node on the path to 'way' away from it.
  function automatic logic [NWAY-2:0] plru_touch(input logic [NWAY-2:0] tree,
                                                 input logic [SWAY-1:0] way);
    logic [NWAY-2:0] t;
    t = tree;
    for (int d = 0; d < int'(SWAY); d++) begin
      for (int p = 0; p < (1 << d); p++) begin
        if ((int'(way) >> (int'(SWAY) - d)) == p) begin
          t[(1 << d) - 1 + p] = ~way[int'(SWAY) - 1 - d];
        end
      end
    end
    return t;
  endfunction

  // Walk from the root following the bits; the leaf reached is the victim.
  function automatic logic [SWAY-1:0] plru_victim(input logic [NWAY-2:0] tree);
    int   vp;
    logic b;
    vp = 0;
    for (int d = 0; d < int'(SWAY); d++) begin
      b = 1'b0;
      for (int p = 0; p < (1 << d); p++) begin
        if (p == vp) b = tree[(1 << d) - 1 + p];
      end
      vp = 2 * vp + int'(b);
    end
    return vp[SWAY-1:0];
  endfunction

  logic [SIDX-1:0] lu_set, fill_set;
  logic [STAG-1:0] lu_tag, fill_tag;

  assign lu_set   = lu_va[SPAGE+SIDX-1:SPAGE];
  assign lu_tag   = lu_va[SADDR-1:SPAGE+SIDX];
  assign fill_set = fill_va[SPAGE+SIDX-1:SPAGE];
  assign fill_tag = fill_va[SADDR-1:SPAGE+SIDX];

  assign flush_busy = (state_q == FLUSH);
  assign fill_ready = !flush_busy && !rst;

  logic fill_fire;
  assign fill_fire = fill_valid && fill_ready;

  logic            lu_hit_c;
  logic [SWAY-1:0] lu_way_c;
  logic [SPPN-1:0] lu_pa_c;

  // Lookup tag compare against the pre-fill contents of the indexed set.
  always_comb begin
    lu_hit_c = 1'b0;
    lu_way_c = '0;
    lu_pa_c  = '0;
    for (int w = 0; w < int'(NWAY); w++) begin
      if (valid_q[lu_set][w] && tag_q[lu_set][w] == lu_tag &&
          pcid_q[lu_set][w] == lu_pcid) begin
        lu_hit_c = 1'b1;
        lu_way_c = w[SWAY-1:0];
        lu_pa_c  = pa_q[lu_set][w];
      end
    end
  end

  logic            fill_match;
  logic [SWAY-1:0] fill_match_way;
  logic            fill_inv;
  logic [SWAY-1:0] fill_inv_way;
  logic [SWAY-1:0] fill_way;

  // Fill way choice: existing matching entry, then lowest invalid, then PLRU victim.
  always_comb begin
    fill_match     = 1'b0;
    fill_match_way = '0;
    fill_inv       = 1'b0;
    fill_inv_way   = '0;
    for (int w = int'(NWAY) - 1; w >= 0; w--) begin
      if (valid_q[fill_set][w] && tag_q[fill_set][w] == fill_tag &&
          pcid_q[fill_set][w] == fill_pcid) begin
        fill_match     = 1'b1;
        fill_match_way = w[SWAY-1:0];
      end
      if (!valid_q[fill_set][w]) begin
        fill_inv     = 1'b1;
        fill_inv_way = w[SWAY-1:0];
      end
    end
    if (fill_match) begin
      fill_way = fill_match_way;
    end else if (fill_inv) begin
      fill_way = fill_inv_way;
    end else begin
      fill_way = plru_victim(plru_q[fill_set]);
    end
  end

`ifdef TLB_PCID_FLUSH_EN
  logic [SPCID-1:0] flush_pcid_q;

  // Target pcid is captured when the flush starts.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && flush_req) flush_pcid_q <= flush_pcid;
  end
`else
  logic unused_flush_pcid;
  assign unused_flush_pcid = ^flush_pcid;
`endif

  logic unused_offset;
  assign unused_offset = ^{lu_va[SPAGE-1:0], fill_va[SPAGE-1:0]};

  // Entry payload writes; no reset needed since valid gates every use.
  always_ff @(posedge clk) begin
    if (fill_fire) begin
      tag_q[fill_set][fill_way]  <= fill_tag;
      pcid_q[fill_set][fill_way] <= fill_pcid;
      pa_q[fill_set][fill_way]   <= fill_pa;
    end
  end

  // Valid bits, PLRU trees, lookup result registers and the flush FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(NSET); s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      lu_done <= 1'b0;
      lu_hit  <= 1'b0;
      lu_pa   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      lu_done <= lu_valid;
      lu_hit  <= lu_valid && !flush_busy && lu_hit_c;
      lu_pa   <= (lu_valid && !flush_busy && lu_hit_c) ? lu_pa_c : '0;

      if (lu_valid && !flush_busy && lu_hit_c) begin
        plru_q[lu_set] <= plru_touch(plru_q[lu_set], lu_way_c);
      end
      // Placed after the lookup update so the fill wins on a same-set collision.
      if (fill_fire) begin
        valid_q[fill_set][fill_way] <= 1'b1;
        plru_q[fill_set]            <= plru_touch(plru_q[fill_set], fill_way);
      end

      case (state_q)
        IDLE: begin
          if (flush_req) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
          end
        end
        FLUSH: begin
`ifdef TLB_PCID_FLUSH_EN
          for (int w = 0; w < int'(NWAY); w++) begin
            if (pcid_q[cnt_q][w] == flush_pcid_q) valid_q[cnt_q][w] <= 1'b0;
          end
`else
          valid_q[cnt_q] <= '0;
          plru_q[cnt_q]  <= '0;
`endif
          cnt_q <= cnt_q + SIDX'(1);
          if (cnt_q == LAST_SET) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_plru_set.sv
// Directed bench for tlb_plru_set (NSET=4, NWAY=4). Lookup results are checked
// through a scoreboard queue; control outputs are checked directly.
module tb_tlb_plru_set;

  localparam int SADDR = 64;
  localparam int SPAGE = 12;
  localparam int NSET  = 4;
  localparam int NWAY  = 4;
  localparam int SPCID = 12;
  localparam int SPPN  = SADDR - SPAGE;

  logic             clk = 1'b0;
  logic             rst;
  logic             lu_valid;
  logic [SADDR-1:0] lu_va;
  logic [SPCID-1:0] lu_pcid;
  logic             lu_done;
  logic             lu_hit;
  logic [SPPN-1:0]  lu_pa;
  logic             fill_valid;
  logic             fill_ready;
  logic [SADDR-1:0] fill_va;
  logic [SPCID-1:0] fill_pcid;
  logic [SPPN-1:0]  fill_pa;
  logic             flush_req;
  logic [SPCID-1:0] flush_pcid;
  logic             flush_busy;

  tlb_plru_set #(
    .SADDR(SADDR), .SPAGE(SPAGE), .NSET(NSET), .NWAY(NWAY), .SPCID(SPCID)
  ) dut (
    .clk(clk), .rst(rst),
    .lu_valid(lu_valid), .lu_va(lu_va), .lu_pcid(lu_pcid),
    .lu_done(lu_done), .lu_hit(lu_hit), .lu_pa(lu_pa),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_va(fill_va),
    .fill_pcid(fill_pcid), .fill_pa(fill_pa),
    .flush_req(flush_req), .flush_pcid(flush_pcid), .flush_busy(flush_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              due;
    logic            hit;
    logic [SPPN-1:0] pa;
    int              id;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc++;

  // Scoreboard: the front entry is due on a given cycle; any other cycle must show lu_done=0.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      checks++;
      assert (lu_done === 1'b1 && lu_hit === e.hit && lu_pa === e.pa) else begin
        failures++;
        $error("FAIL lookup%0d observed done=%b hit=%b pa=%h expected done=1 hit=%b pa=%h",
               e.id, lu_done, lu_hit, lu_pa, e.hit, e.pa);
      end
    end else begin
      checks++;
      assert (lu_done === 1'b0) else begin
        failures++;
        $error("FAIL idle_done cycle=%0d observed=%b expected=0", cyc, lu_done);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic hit, input logic [SPPN-1:0] pa, input int id);
    exp_t e;
    e.due = cyc + 1;
    e.hit = hit;
    e.pa  = hit ? pa : '0;
    e.id  = id;
    sbq.push_back(e);
  endtask

  task automatic lookup(input logic [SADDR-1:0] va, input logic [SPCID-1:0] pcid,
                        input logic hit, input logic [SPPN-1:0] pa, input int id);
    lu_valid = 1'b1;
    lu_va    = va;
    lu_pcid  = pcid;
    push_exp(hit, pa, id);
    @(negedge clk);
    lu_valid = 1'b0;
  endtask

  task automatic fill(input logic [SADDR-1:0] va, input logic [SPCID-1:0] pcid,
                      input logic [SPPN-1:0] pa, input string tag);
    fill_valid = 1'b1;
    fill_va    = va;
    fill_pcid  = pcid;
    fill_pa    = pa;
    #1 chk(tag, 64'(fill_ready), 64'd1);
    @(negedge clk);
    fill_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lu_valid = 1'b0; lu_va = '0; lu_pcid = '0;
    fill_valid = 1'b0; fill_va = '0; fill_pcid = '0; fill_pa = '0;
    flush_req = 1'b0; flush_pcid = '0;

    repeat (2) @(negedge clk);
    chk("rst_fill_ready", 64'(fill_ready), 64'd0);
    chk("rst_busy", 64'(flush_busy), 64'd0);
    chk("rst_hit", 64'(lu_hit), 64'd0);
    chk("rst_pa", 64'(lu_pa), 64'd0);
    rst = 1'b0;
    #1 chk("idle_fill_ready", 64'(fill_ready), 64'd1);

    lookup(64'h1000, 12'd3, 1'b0, '0, 0);                // empty after reset

    // Basic fill and lookup, pcid mismatch
    fill(64'h1000, 12'd3, 52'hABC, "fill_a");
    lookup(64'h1000, 12'd3, 1'b1, 52'hABC, 1);
    lookup(64'h1000, 12'd4, 1'b0, '0, 2);

    // Fill set 1 to capacity, touch ways 0 and 2, then replace: PLRU victim is way 1
    fill(64'h5000, 12'd3, 52'h111, "fill_b");
    fill(64'h9000, 12'd3, 52'h222, "fill_c");
    fill(64'hD000, 12'd3, 52'h333, "fill_d");
    lookup(64'h1000, 12'd3, 1'b1, 52'hABC, 3);
    lookup(64'h9000, 12'd3, 1'b1, 52'h222, 4);
    fill(64'h11000, 12'd3, 52'h444, "fill_e");
    lookup(64'h5000, 12'd3, 1'b0, '0, 5);
    lookup(64'h11000, 12'd3, 1'b1, 52'h444, 6);

    // Refill of a present entry overwrites in place; all other tags survive
    fill(64'h1000, 12'd3, 52'hDEF, "refill_a");
    lookup(64'h1000, 12'd3, 1'b1, 52'hDEF, 7);
    lookup(64'h9000, 12'd3, 1'b1, 52'h222, 8);
    lookup(64'hD000, 12'd3, 1'b1, 52'h333, 9);
    lookup(64'h11000, 12'd3, 1'b1, 52'h444, 10);

    // Same-cycle lookup and fill: lookup sees pre-fill contents
    fill_valid = 1'b1; fill_va = 64'h2000; fill_pcid = 12'd5; fill_pa = 52'h555;
    lu_valid = 1'b1; lu_va = 64'h2000; lu_pcid = 12'd5;
    push_exp(1'b0, '0, 11);
    #1 chk("fill_same_cycle_ready", 64'(fill_ready), 64'd1);
    @(negedge clk);
    fill_valid = 1'b0; lu_valid = 1'b0;
    lookup(64'h2000, 12'd5, 1'b1, 52'h555, 12);

    // Flush: busy for exactly NSET cycles, lookups miss, a re-request mid-flush is ignored
    flush_req = 1'b1; flush_pcid = 12'd3;
    @(negedge clk);
    flush_req = 1'b0;
    for (int i = 0; i < NSET; i++) begin
      chk($sformatf("flush_busy_%0d", i), 64'(flush_busy), 64'd1);
      chk($sformatf("flush_fill_ready_%0d", i), 64'(fill_ready), 64'd0);
      flush_req = (i == 1);
      lookup(64'h2000, 12'd5, 1'b0, '0, 20 + i);
    end
    flush_req = 1'b0;
    chk("flush_done_busy", 64'(flush_busy), 64'd0);
    chk("flush_done_ready", 64'(fill_ready), 64'd1);
`ifdef TLB_PCID_FLUSH_EN
    lookup(64'h1000, 12'd3, 1'b0, '0, 30);
    lookup(64'h9000, 12'd3, 1'b0, '0, 31);
    lookup(64'h2000, 12'd5, 1'b1, 52'h555, 32);
`else
    lookup(64'h1000, 12'd3, 1'b0, '0, 30);
    lookup(64'h9000, 12'd3, 1'b0, '0, 31);
    lookup(64'h2000, 12'd5, 1'b0, '0, 32);
`endif

    // Reset in the second flush cycle aborts the flush
    fill(64'h1000, 12'd3, 52'hABC, "fill_pre_abort");
    lookup(64'h1000, 12'd3, 1'b1, 52'hABC, 40);
    flush_req = 1'b1; flush_pcid = 12'd3;
    @(negedge clk);
    flush_req = 1'b0;
    chk("abort_busy_c1", 64'(flush_busy), 64'd1);
    @(negedge clk);
    chk("abort_busy_c2", 64'(flush_busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy_after", 64'(flush_busy), 64'd0);
    rst = 1'b0;
    fill(64'h3000, 12'd7, 52'h777, "fill_after_abort");
    lookup(64'h1000, 12'd3, 1'b0, '0, 41);
    lookup(64'h2000, 12'd5, 1'b0, '0, 42);
    lookup(64'h3000, 12'd7, 1'b1, 52'h777, 43);
    chk("post_abort_busy", 64'(flush_busy), 64'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlb_plru_set.md
TLB_PLRU_SET -- requirements
Module: tlb_plru_set

Interface
REQ-001 The block SHALL use these parameters:
- SADDR, default 64, address width.
- SPAGE, default 12, page-offset width.
- NSET, default 8, number of sets (power of 2, at least 2).
- NWAY, default 8, ways per set (power of 2, at least 2).
- SPCID, default 12, PCID width.
REQ-002 The block SHALL use these ports (clock and reset first):
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- lu_valid  in  1  lookup request.
- lu_va  in  SADDR  lookup virtual address.
- lu_pcid  in  SPCID  lookup PCID.
- lu_done  out  1  lookup result valid.
- lu_hit  out  1  lookup hit.
- lu_pa  out  SADDR-SPAGE  physical page number on hit, 0 on miss.
- fill_valid  in  1  fill request.
- fill_ready  out  1  fill accepted this cycle.
- fill_va  in  SADDR  fill virtual address.
- fill_pcid  in  SPCID  fill PCID.
- fill_pa  in  SADDR-SPAGE  fill physical page number.
- flush_req  in  1  start flush.
- flush_pcid  in  SPCID  flush target PCID.
- flush_busy  out  1  flush in progress.

Function
REQ-003 The set index SHALL be va[SPAGE+log2(NSET)-1:SPAGE]; the tag SHALL be va[SADDR-1:SPAGE+log2(NSET)].
REQ-004 Each entry SHALL hold valid, tag, pcid and pa; each set SHALL hold an NWAY-1 bit PLRU tree (node i has children 2i+1 and 2i+2; 0 = left, 1 = right; the leaves map to ways 0..NWAY-1 from left to right).
REQ-005 A lookup SHALL hit when some way in the indexed set has valid=1, a matching tag and a matching pcid.
REQ-006 Lookup latency SHALL be 1 cycle: lu_valid sampled at edge N gives lu_done=1 together with lu_hit/lu_pa registered at edge N+1; lu_done SHALL be 0 otherwise.
REQ-007 On a hit, the PLRU path bits of the indexed set SHALL be set to point away from the hit way at the same edge the result registers.
REQ-008 fill_ready SHALL equal !flush_busy && !rst, combinationally; a fill SHALL be accepted when fill_valid && fill_ready.
REQ-009 Fill way selection SHALL use this priority:
- the way already holding a matching valid tag and pcid (overwrite pa);
- else the lowest-index invalid way;
- else the PLRU victim (walk from the root following the bits).
REQ-010 An accepted fill SHALL write the entry with valid=1 and update the PLRU to point away from the written way.
REQ-011 When a lookup and a fill arrive in the same cycle, the lookup SHALL see the pre-fill contents.
REQ-012 If both target the same set in the same cycle, the fill's PLRU update SHALL win.
REQ-013 The flush FSM SHALL have two states, IDLE and FLUSH:
- flush_req in IDLE moves to FLUSH, latches flush_pcid and clears the set counter;
- FLUSH processes one set per cycle, walking sets 0..NSET-1;
- FLUSH returns to IDLE after set NSET-1, so it lasts exactly NSET cycles;
- flush_busy=1 exactly while in FLUSH;
- flush_req is ignored while in FLUSH.
REQ-014 While flush_busy=1, lookups SHALL complete with lu_done=1, lu_hit=0, lu_pa=0, and SHALL NOT update the PLRU.
REQ-015 Flushed sets SHALL have their PLRU cleared to 0.
REQ-016 The set counter SHALL be log2(NSET) bits wide and SHALL wrap to 0 on exit from FLUSH.

Reset
REQ-017 While rst=1 at an edge, the block SHALL clear every valid bit and PLRU bit, set lu_done=0, lu_hit=0, lu_pa=0, and enter IDLE.
REQ-018 Reset asserted mid-flush SHALL abort the flush, and flush_busy SHALL read 0 in the next cycle.
REQ-019 tag, pcid and pa storage MAY retain stale values after reset; valid=0 SHALL mask them.

Configuration
REQ-020 With TLB_PCID_FLUSH_EN defined, FLUSH SHALL clear only entries whose pcid equals the latched flush_pcid, and SHALL leave the PLRU unchanged (this overrides REQ-015).
REQ-021 Without TLB_PCID_FLUSH_EN, FLUSH SHALL clear every entry regardless of pcid, flush_pcid SHALL be ignored, and REQ-015 applies.

Verification (NSET=4, NWAY=4, SPAGE=12)
REQ-022 Fill va=0x1000, pcid=3, pa=0xABC, then look up the same va and pcid -> lu_done=1, lu_hit=1, lu_pa=0xABC one cycle later; the same va with pcid=4 -> lu_hit=0, lu_pa=0.
REQ-023 Fill 4 tags into set 1, touch ways 0 and 2 by lookup, then fill a 5th tag -> way 1 is replaced; a lookup of the old way-1 tag misses.
REQ-024 Refill an existing va=0x1000, pcid=3 with pa=0xDEF -> subsequent lookup gives lu_pa=0xDEF, and no second way in set 1 becomes valid.
REQ-025 Pulse flush_req with flush_pcid=3 -> flush_busy=1 for exactly 4 cycles, fill_ready=0 and lookups miss during it.
- With TLB_PCID_FLUSH_EN: pcid 3 entries miss afterwards, pcid 5 entries still hit.
- Without TLB_PCID_FLUSH_EN: all entries miss.
REQ-026 Assert rst in the 2nd flush cycle -> next cycle flush_busy=0, all lookups miss, and a fill is accepted immediately.
